// File: rtl/fetch_cache_if.sv
// Processor- and slowmem-side signal bundle for fetch_cache.
// Optional hits/misses counters exist only when CACHE_STATS_EN is defined.
interface fetch_cache_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    // processor side
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rnotw;
    logic          strobe;
    logic          inval;
    logic          mfc;
    logic [DW-1:0] rdata;
    logic          busy;
    // slowmem side
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    logic          mrnotw;
    logic          mstrobe;
    logic          mmfc;
    logic [DW-1:0] mrdata;
`ifdef CACHE_STATS_EN
    logic [15:0]   hits;
    logic [15:0]   misses;
`endif

    // slave: the cache itself; master: processor plus slowmem around it
    modport slave (
        input  addr, wdata, rnotw, strobe, inval, mmfc, mrdata,
        output mfc, rdata, busy, maddr, mwdata, mrnotw, mstrobe
`ifdef CACHE_STATS_EN
        , output hits, misses
`endif
    );

    modport master (
        output addr, wdata, rnotw, strobe, inval, mmfc, mrdata,
        input  mfc, rdata, busy, maddr, mwdata, mrnotw, mstrobe
`ifdef CACHE_STATS_EN
        , input hits, misses
`endif
    );
endinterface

// File: rtl/fetch_cache.sv
// Direct-mapped, write-through, one-word-per-line cache in front of slowmem.
// Define CACHE_STATS_EN to add saturating hits/misses counters.
module fetch_cache #(
    parameter int IDX_BITS = 3,
    parameter int AW       = 16,
    parameter int DW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_cache_if.slave  bus
);
    localparam int LINES = 2 ** IDX_BITS;
    localparam int TAG_W = AW - IDX_BITS;

    typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [TAG_W-1:0]       tag_d  [LINES];
    logic [DW-1:0]          data_q [LINES];
    logic [DW-1:0]          data_d [LINES];
    logic                   mfc_q, mfc_d;
    logic [DW-1:0]          rdata_q, rdata_d;
    logic                   busy_q, busy_d;
    logic                   mstrobe_q, mstrobe_d;
    logic                   mrnotw_q, mrnotw_d;
    logic [AW-1:0]          maddr_q, maddr_d;
    logic [DW-1:0]          mwdata_q, mwdata_d;
`ifdef CACHE_STATS_EN
    logic [15:0]            hits_q, hits_d;
    logic [15:0]            misses_q, misses_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    logic [IDX_BITS-1:0]    req_idx, fill_idx;
    logic [TAG_W-1:0]       req_tag, fill_tag;
    logic                   req_hit;

    assign req_idx  = bus.addr[IDX_BITS-1:0];
    assign req_tag  = bus.addr[AW-1:IDX_BITS];
    assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    // the missing address is held in maddr for the whole fill
    assign fill_idx = maddr_q[IDX_BITS-1:0];
    assign fill_tag = maddr_q[AW-1:IDX_BITS];

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        mfc_d     = 1'b0;
        rdata_d   = '0;
        mstrobe_d = 1'b0;
        mrnotw_d  = mrnotw_q;
        maddr_d   = maddr_q;
        mwdata_d  = mwdata_q;
`ifdef CACHE_STATS_EN
        hits_d    = hits_q;
        misses_d  = misses_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.strobe) begin
                    if (bus.rnotw) begin
                        if (req_hit) begin
                            mfc_d   = 1'b1;
                            rdata_d = data_q[req_idx];
`ifdef CACHE_STATS_EN
                            hits_d  = sat_inc(hits_q);
`endif
                        end else begin
                            maddr_d   = bus.addr;
                            mrnotw_d  = 1'b1;
                            mstrobe_d = 1'b1;
                            state_d   = MISS_REQ;
`ifdef CACHE_STATS_EN
                            misses_d  = sat_inc(misses_q);
`endif
                        end
                    end else begin
                        // write-through with allocate; completes without waiting on slowmem
                        maddr_d          = bus.addr;
                        mwdata_d         = bus.wdata;
                        mrnotw_d         = 1'b0;
                        mstrobe_d        = 1'b1;
                        mfc_d            = 1'b1;
                        valid_d[req_idx] = 1'b1;
                        tag_d[req_idx]   = req_tag;
                        data_d[req_idx]  = bus.wdata;
                    end
                end else if (bus.inval) begin
                    valid_d = '0;
                end
            end
            MISS_REQ: begin
                state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                if (bus.mmfc) begin
                    valid_d[fill_idx] = 1'b1;
                    tag_d[fill_idx]   = fill_tag;
                    data_d[fill_idx]  = bus.mrdata;
                    mfc_d             = 1'b1;
                    rdata_d           = bus.mrdata;
                    state_d           = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            mfc_q     <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            mstrobe_q <= 1'b0;
            mrnotw_q  <= 1'b1;
            maddr_q   <= '0;
            mwdata_q  <= '0;
`ifdef CACHE_STATS_EN
            hits_q    <= '0;
            misses_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            mfc_q     <= mfc_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            mstrobe_q <= mstrobe_d;
            mrnotw_q  <= mrnotw_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
`ifdef CACHE_STATS_EN
            hits_q    <= hits_d;
            misses_q  <= misses_d;
`endif
        end
    end

    // line payload needs no reset: valid bits gate every use
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign bus.mfc     = mfc_q;
    assign bus.rdata   = rdata_q;
    assign bus.busy    = busy_q;
    assign bus.mstrobe = mstrobe_q;
    assign bus.mrnotw  = mrnotw_q;
    assign bus.maddr   = maddr_q;
    assign bus.mwdata  = mwdata_q;
`ifdef CACHE_STATS_EN
    assign bus.hits    = hits_q;
    assign bus.misses  = misses_q;
`endif
endmodule

// File: tb/tb_fetch_cache.sv
// Directed bench for fetch_cache against a MEMDELAY=4 slowmem model.
module tb_fetch_cache;
    localparam int MEMDELAY = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_cache_if #(.AW(16), .DW(16)) bus ();

    fetch_cache #(.IDX_BITS(3), .AW(16), .DW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // slowmem model: contents start as addr ^ 16'hC000
    logic [15:0] mem [0:65535];
    int          mcnt = 0;
    logic [15:0] m_addr;
    logic        m_rw;

    always @(posedge clk) begin
        bus.mmfc <= 1'b0;
        if (bus.mstrobe) begin
            mcnt   <= MEMDELAY;
            m_addr <= bus.maddr;
            m_rw   <= bus.mrnotw;
            if (!bus.mrnotw) mem[bus.maddr] <= bus.mwdata;
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end else if (mcnt == 1) begin
            mcnt       <= 0;
            bus.mmfc   <= 1'b1;
            bus.mrdata <= m_rw ? mem[m_addr] : 16'h0000;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          lat, nstb, cnt_mfc, cnt_stb;
    logic [15:0] rd, s_addr, s_wdata;
    logic        s_rnotw;

    // Call just after a posedge; strobe is held until mfc is seen.
    task automatic do_req(input logic [15:0] a, input logic [15:0] d, input logic rw);
        bus.addr   = a;
        bus.wdata  = d;
        bus.rnotw  = rw;
        bus.strobe = 1'b1;
        lat  = 0;
        nstb = 0;
        rd   = 16'hxxxx;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.mstrobe) begin
                nstb++;
                s_addr  = bus.maddr;
                s_rnotw = bus.mrnotw;
                s_wdata = bus.mwdata;
            end
            if (bus.mfc) begin
                rd = bus.rdata;
                break;
            end
            if (i == 39) lat = -1;
        end
        bus.strobe = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hC000;
        bus.addr = '0; bus.wdata = '0; bus.rnotw = 1'b1;
        bus.strobe = 1'b0; bus.inval = 1'b0;
        bus.mmfc = 1'b0; bus.mrdata = '0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        check_eq("rst_mfc",     32'(bus.mfc),     32'h0);
        check_eq("rst_rdata",   32'(bus.rdata),   32'h0);
        check_eq("rst_busy",    32'(bus.busy),    32'h0);
        check_eq("rst_mstrobe", 32'(bus.mstrobe), 32'h0);
        check_eq("rst_mrnotw",  32'(bus.mrnotw),  32'h1);
        check_eq("rst_maddr",   32'(bus.maddr),   32'h0);
        check_eq("rst_mwdata",  32'(bus.mwdata),  32'h0);

        // cold miss
        do_req(16'h0003, 16'h0, 1'b1);
        check_eq("miss3_lat",    32'(lat),     32'd7);
        check_eq("miss3_rdata",  32'(rd),      32'hC003);
        check_eq("miss3_nstb",   32'(nstb),    32'd1);
        check_eq("miss3_maddr",  32'(s_addr),  32'h0003);
        check_eq("miss3_mrnotw", 32'(s_rnotw), 32'h1);
        check_eq("miss3_busy",   32'(bus.busy), 32'h0);

        // hit
        do_req(16'h0003, 16'h0, 1'b1);
        check_eq("hit3_lat",   32'(lat),  32'd1);
        check_eq("hit3_rdata", 32'(rd),   32'hC003);
        check_eq("hit3_nstb",  32'(nstb), 32'd0);
`ifdef CACHE_STATS_EN
        check_eq("stat_hits",   32'(bus.hits),   32'd1);
        check_eq("stat_misses", 32'(bus.misses), 32'd1);
`endif

        // conflict eviction on index 3
        do_req(16'h000B, 16'h0, 1'b1);
        check_eq("missB_lat",   32'(lat), 32'd7);
        check_eq("missB_rdata", 32'(rd),  32'hC00B);
        do_req(16'h0003, 16'h0, 1'b1);
        check_eq("evict3_lat",   32'(lat), 32'd7);
        check_eq("evict3_rdata", 32'(rd),  32'hC003);

        // write-through with allocate
        do_req(16'h8005, 16'hBEEF, 1'b0);
        check_eq("wr_lat",    32'(lat),     32'd1);
        check_eq("wr_nstb",   32'(nstb),    32'd1);
        check_eq("wr_mrnotw", 32'(s_rnotw), 32'h0);
        check_eq("wr_maddr",  32'(s_addr),  32'h8005);
        check_eq("wr_mwdata", 32'(s_wdata), 32'hBEEF);
        check_eq("wr_rdata",  32'(rd),      32'h0);
        do_req(16'h8005, 16'h0, 1'b1);
        check_eq("rdw_lat",   32'(lat), 32'd1);
        check_eq("rdw_rdata", 32'(rd),  32'hBEEF);

        // address wrap
        do_req(16'hFFFF, 16'h1234, 1'b0);
        do_req(16'hFFFF, 16'h0, 1'b1);
        check_eq("wrap_lat",   32'(lat), 32'd1);
        check_eq("wrap_rdata", 32'(rd),  32'h1234);
        repeat (8) @(posedge clk);
        #1;

        // reset abandons an in-flight miss
        bus.addr = 16'h0010; bus.rnotw = 1'b1; bus.strobe = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_busy_before", 32'(bus.busy), 32'h1);
        bus.strobe = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check_eq("abort_busy_after", 32'(bus.busy),    32'h0);
        check_eq("abort_mfc_after",  32'(bus.mfc),     32'h0);
        check_eq("abort_mrnotw",     32'(bus.mrnotw),  32'h1);
        cnt_mfc = 0;
        cnt_stb = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.mfc) cnt_mfc++;
            if (bus.mstrobe) cnt_stb++;
        end
        check_eq("abort_late_mfc", 32'(cnt_mfc), 32'd0);
        check_eq("abort_late_stb", 32'(cnt_stb), 32'd0);
        do_req(16'h0010, 16'h0, 1'b1);
        check_eq("abort_rd_lat",   32'(lat),  32'd7);
        check_eq("abort_rd_nstb",  32'(nstb), 32'd1);
        check_eq("abort_rd_rdata", 32'(rd),   32'hC010);

        // invalidate
        do_req(16'h0001, 16'h0, 1'b1);
        check_eq("fill1_lat", 32'(lat), 32'd7);
        do_req(16'h0001, 16'h0, 1'b1);
        check_eq("hit1_lat", 32'(lat), 32'd1);
        bus.inval = 1'b1;
        @(posedge clk); #1;
        bus.inval = 1'b0;
        do_req(16'h0001, 16'h0, 1'b1);
        check_eq("inval1_lat",   32'(lat),  32'd7);
        check_eq("inval1_nstb",  32'(nstb), 32'd1);
        check_eq("inval1_rdata", 32'(rd),   32'hC001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_cache.md
Name: fetch_cache

Overview:
- Direct-mapped, write-through, one-word-per-line cache placed between the two-thread stack processor's fetch/data interface and `slowmem`.
- It hides the `MEMDELAY` read latency on hits.
- On a miss it runs a `slowmem` read transaction and fills the line.
- Writes are forwarded to `slowmem` immediately and also update (allocate) the line.
- The processor sees the same `addr`/`wdata`/`rnotw`/`strobe` → `mfc`/`rdata` protocol that `slowmem` presents, plus a `busy` flag.

Parameters:
- IDX_BITS, 3, index width; lines = 2**IDX_BITS (8, matching `CACHESIZE`).
- AW, 16, word-address width; tag width = AW-IDX_BITS (13).
- DW, 16, data word width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk, 0 = reset.
- addr  in  AW  processor word address.
- wdata  in  DW  processor write data.
- rnotw  in  1  1 = read, 0 = write.
- strobe  in  1  request valid; sampled only when busy=0.
- inval  in  1  invalidate all lines; honoured only in IDLE when strobe=0.
- mfc  out  1  one-cycle pulse: read data valid / write accepted.
- rdata  out  DW  read data, valid only while mfc=1.
- busy  out  1  1 in any state other than IDLE.
- maddr  out  AW  to slowmem addr.
- mwdata  out  DW  to slowmem wdata.
- mrnotw  out  1  to slowmem rnotw.
- mstrobe  out  1  to slowmem strobe.
- mmfc  in  1  from slowmem mfc.
- mrdata  in  DW  from slowmem rdata.

Behaviour:
- Storage per line: valid bit, tag[AW-1:IDX_BITS], data[DW]. index = addr[IDX_BITS-1:0].
- Reset (reset=0 at posedge):
  - state=IDLE, all valid=0.
  - mfc=0, rdata=0, busy=0, mstrobe=0, mrnotw=1, maddr=0, mwdata=0.
  - Counters (if enabled) = 0.
  - Reset takes effect from any state; an in-flight miss is abandoned and any late mmfc is ignored.
- All outputs are registered. mstrobe and mfc are single-cycle pulses.
- FSM states:
  - IDLE
  - MISS_REQ
  - MISS_WAIT
- IDLE, strobe=1, rnotw=1, hit (valid && tag match):
  - Next cycle mfc=1, rdata=line data.
  - Stay in IDLE. Hit latency = 1 cycle. Back-to-back hits are allowed every cycle.
- IDLE, strobe=1, rnotw=1, miss:
  - Latch addr → maddr.
  - Next cycle: state=MISS_REQ, busy=1, mstrobe=1, mrnotw=1.
- MISS_REQ: unconditionally go to MISS_WAIT next cycle; mstrobe drops to 0.
- MISS_WAIT, while mmfc=0: hold.
- MISS_WAIT, mmfc=1:
  - Write mrdata into the line; set valid=1 and tag=latched tag.
  - Next cycle mfc=1, rdata=mrdata, busy=0, state=IDLE.
- Miss latency with MEMDELAY=4: response mfc appears 7 cycles after the strobe cycle. The bench checks the exact value.
- IDLE, strobe=1, rnotw=0 (write):
  - Next cycle: mstrobe=1, mrnotw=0, maddr=addr, mwdata=wdata.
  - Line written with valid=1, tag=addr tag, data=wdata (write-allocate; an evicted line is simply overwritten).
  - mfc=1 in the same cycle; state stays IDLE. No read data is returned; rdata is 0.
- strobe while busy=1 is ignored; the requester must hold strobe until it sees mfc.
- inval in IDLE with strobe=0 clears all valid bits next cycle.
  - If strobe=1 in the same cycle, strobe wins and inval is dropped.
  - inval while busy is ignored.
- Simultaneous mmfc and reset: reset wins and no fill occurs.
- Address wrap: no special case; addr 16'hFFFF maps to index 7, tag 13'h1FFF.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds outputs `hits` (out, 16) and `misses` (out, 16).
  - `hits` increments on each read hit response; `misses` increments on each transition into MISS_REQ.
  - Both saturate at 16'hFFFF and clear on reset.
  - Writes are counted in neither.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset held low 2 cycles then high → all outputs 0 except mrnotw=1; read addr 16'h0003 → miss: mstrobe pulse with maddr=3, mrnotw=1; mfc=1 with rdata=mem[3] 7 cycles after strobe.
- Repeat read 16'h0003 → mfc=1 exactly 1 cycle later, rdata=mem[3], mstrobe stays 0; with CACHE_STATS_EN, hits=1 and misses=1.
- Read 16'h000B (same index 3, different tag) → miss refill; then read 16'h0003 → miss again (conflict eviction).
- Write 16'h8005 with data 16'hBEEF → mstrobe=1, mrnotw=0, maddr=8005, mwdata=BEEF, mfc=1 next cycle; then read 8005 → 1-cycle hit returning BEEF.
- Start a miss on 16'h0010, drive reset=0 during MISS_WAIT → state IDLE, busy=0, a later mmfc produces no mfc; read 16'h0010 → miss again (line not valid).
- Fill 16'h0001, pulse inval in IDLE → read 16'h0001 misses; strobe asserted during MISS_WAIT is ignored (no second mstrobe).
